// File: rtl/sram_like_req_tracker.sv
// In-order outstanding-request tracker for an SRAM-like master port.
// Define SRAM_LIKE_RDATA_HOLD_EN to hold the last delivered rdata.
module sram_like_req_tracker #(
   parameter int DATA_W          = 32,
   parameter int ADDR_W          = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              core_req,
   input  logic              core_wr,
   input  logic [1:0]        core_size,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_ack,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   output logic              busy,
   output logic              req,
   output logic              wr,
   output logic [1:0]        size,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   input  logic              addr_ok,
   input  logic              data_ok,
   input  logic [DATA_W-1:0] rdata
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [CNT_W-1:0] out_cnt;
   logic [CNT_W-1:0] drop_cnt;
   logic [CNT_W-1:0] out_cnt_nxt;
   logic [CNT_W-1:0] drop_cnt_nxt;
   logic             accept;
   logic             resp;

   // Full check uses only registered state: no addr_ok/data_ok -> req path.
   assign req   = core_req & ~flush & (out_cnt != MAX_CNT);
   assign wr    = core_wr;
   assign size  = core_size;
   assign addr  = core_addr;
   assign wdata = core_wdata;

   assign accept      = req & addr_ok;
   assign core_ack    = accept;
   assign resp        = data_ok & (out_cnt != '0);
   assign core_rvalid = resp & (drop_cnt == '0);
   assign busy        = (core_req & ~accept) | (out_cnt != drop_cnt);

   always_comb begin
      out_cnt_nxt = out_cnt;
      if (accept && !resp) begin
         out_cnt_nxt = out_cnt + ONE;
      end else if (!accept && resp) begin
         out_cnt_nxt = out_cnt - ONE;
      end
   end

   // A flush marks everything still outstanding after this cycle as stale.
   always_comb begin
      drop_cnt_nxt = drop_cnt;
      if (flush) begin
         drop_cnt_nxt = out_cnt_nxt;
      end else if (resp && (drop_cnt != '0)) begin
         drop_cnt_nxt = drop_cnt - ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         out_cnt  <= out_cnt_nxt;
         drop_cnt <= drop_cnt_nxt;
      end
   end

`ifdef SRAM_LIKE_RDATA_HOLD_EN
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (core_rvalid) begin
         rdata_q <= rdata;
      end
   end

   assign core_rdata = core_rvalid ? rdata : rdata_q;
`else
   assign core_rdata = rdata;
`endif

endmodule

// File: tb/tb_sram_like_req_tracker.sv
// Bench for sram_like_req_tracker: vector table plus
// hand sequences, in-order rdata scoreboard on the MAX=2 instance.
module tb_sram_like_req_tracker;

`ifdef SRAM_LIKE_RDATA_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        core_req;
   logic        core_wr;
   logic [1:0]  core_size;
   logic [31:0] core_addr;
   logic [31:0] core_wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   logic        m_ack, m_rvalid, m_busy, m_req, m_wr;
   logic [1:0]  m_size;
   logic [31:0] m_rdata, m_addr, m_wdata;
   logic        s_ack, s_rvalid, s_busy, s_req, s_wr;
   logic [1:0]  s_size;
   logic [31:0] s_rdata, s_addr, s_wdata;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   sram_like_req_tracker #(
      .DATA_W(32), .ADDR_W(32), .MAX_OUTSTANDING(2)
   ) u_m (
      .clk(clk), .rst(rst), .flush(flush),
      .core_req(core_req), .core_wr(core_wr),
      .core_size(core_size), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_ack(m_ack),
      .core_rvalid(m_rvalid), .core_rdata(m_rdata),
      .busy(m_busy), .req(m_req), .wr(m_wr),
      .size(m_size), .addr(m_addr), .wdata(m_wdata),
      .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
   );

   sram_like_req_tracker #(
      .DATA_W(32), .ADDR_W(32), .MAX_OUTSTANDING(1)
   ) u_s (
      .clk(clk), .rst(rst), .flush(flush),
      .core_req(core_req), .core_wr(core_wr),
      .core_size(core_size), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_ack(s_ack),
      .core_rvalid(s_rvalid), .core_rdata(s_rdata),
      .busy(s_busy), .req(s_req), .wr(s_wr),
      .size(s_size), .addr(s_addr), .wdata(s_wdata),
      .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
   );

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   // Scoreboard: every delivered response must match the queue head.
   always @(negedge clk) begin
      if (m_rvalid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got %h want none", m_rdata);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (m_rdata !== e) begin
               errors++;
               $display("FAIL sb_rdata got %h want %h", m_rdata, e);
            end
         end
      end
   end

   typedef struct packed {
      logic        rst;
      logic        fl;
      logic        cr;
      logic        ao;
      logic        dk;
      logic [31:0] rd;
      logic        ck;
      logic        e_req;
      logic        e_ack;
      logic        e_rv;
      logic        e_busy;
   } vec_t;

   vec_t tbl[0:24];

   task automatic idle();
      flush = 0; core_req = 0; addr_ok = 0;
      data_ok = 0; rdata = 0;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic do_rst();
      idle();
      rst = 1;
      next();
      rst = 0;
   endtask

   initial begin
      //        rst fl cr ao dk rd      ck rq ak rv by
      tbl[0]  = '{1,0,0,0,0,32'h0,  0,0,0,0,0};
      tbl[1]  = '{0,0,0,0,0,32'h0,  1,0,0,0,0};
      tbl[2]  = '{0,0,0,0,1,32'h99, 1,0,0,0,0};
      tbl[3]  = '{0,0,1,0,0,32'h0,  1,1,0,0,1};
      tbl[4]  = '{0,0,1,1,0,32'h0,  1,1,1,0,0};
      tbl[5]  = '{0,0,1,1,0,32'h0,  1,1,1,0,1};
      tbl[6]  = '{0,0,1,1,0,32'h0,  1,0,0,0,1};
      tbl[7]  = '{0,0,1,1,1,32'h11, 1,0,0,1,1};
      tbl[8]  = '{0,0,1,1,1,32'h22, 1,1,1,1,1};
      tbl[9]  = '{0,0,0,0,1,32'h33, 1,0,0,1,1};
      tbl[10] = '{0,0,0,0,0,32'h0,  1,0,0,0,0};
      tbl[11] = '{0,0,1,1,0,32'h0,  1,1,1,0,0};
      tbl[12] = '{0,0,1,1,0,32'h0,  1,1,1,0,1};
      tbl[13] = '{0,1,1,1,0,32'h0,  1,0,0,0,1};
      tbl[14] = '{0,0,1,1,1,32'hAA, 1,0,0,0,1};
      tbl[15] = '{0,0,1,1,1,32'hBB, 1,1,1,0,0};
      tbl[16] = '{0,0,0,0,1,32'hCC, 1,0,0,1,1};
      tbl[17] = '{0,0,0,0,0,32'h0,  1,0,0,0,0};
      tbl[18] = '{0,0,1,1,0,32'h0,  1,1,1,0,0};
      tbl[19] = '{0,1,0,0,1,32'h44, 1,0,0,1,1};
      tbl[20] = '{0,0,0,0,0,32'h0,  1,0,0,0,0};
      tbl[21] = '{0,0,1,1,0,32'h0,  1,1,1,0,0};
      tbl[22] = '{1,0,0,0,0,32'h0,  1,0,0,0,1};
      tbl[23] = '{0,0,0,0,1,32'h55, 1,0,0,0,0};
      tbl[24] = '{0,0,1,0,0,32'h0,  1,1,0,0,1};

      rst = 1; idle();
      core_wr = 0; core_size = 0;
      core_addr = 0; core_wdata = 0;
      #1;

      for (int i = 0; i < 25; i++) begin
         vec_t v;
         v = tbl[i];
         rst = v.rst; flush = v.fl;
         core_req = v.cr; addr_ok = v.ao;
         data_ok = v.dk; rdata = v.rd;
         core_addr = 32'h8000_0100 + 32'(i * 4);
         core_wdata = 32'hC0DE_0000 + 32'(i);
         core_wr = 1'(i & 1);
         core_size = 2'(i);
         if (v.e_rv) exp_q.push_back(v.rd);
         @(negedge clk);
         if (v.ck) begin
            chk($sformatf("v%0d_req", i), 32'(m_req), 32'(v.e_req));
            chk($sformatf("v%0d_ack", i), 32'(m_ack), 32'(v.e_ack));
            chk($sformatf("v%0d_rv", i), 32'(m_rvalid), 32'(v.e_rv));
            chk($sformatf("v%0d_busy", i), 32'(m_busy), 32'(v.e_busy));
            chk($sformatf("v%0d_addr", i), m_addr, core_addr);
            chk($sformatf("v%0d_wdata", i), m_wdata, core_wdata);
            chk($sformatf("v%0d_wr", i), 32'(m_wr), 32'(i & 1));
            chk($sformatf("v%0d_size", i), 32'(m_size), 32'(i & 3));
         end
         next();
      end

      // Single read on the MAX=1 instance.
      do_rst();
      core_req = 1; addr_ok = 1; core_addr = 32'hBFC0_0000;
      @(negedge clk);
      chk("s1_ack", 32'(s_ack), 32'd1);
      chk("s1_addr", s_addr, 32'hBFC0_0000);
      next();
      @(negedge clk);
      chk("s2_req", 32'(s_req), 32'd0);
      chk("s2_ack", 32'(s_ack), 32'd0);
      next();
      core_req = 0; addr_ok = 0;
      data_ok = 1; rdata = 32'h3C08_0001;
      exp_q.push_back(32'h3C08_0001);
      @(negedge clk);
      chk("s3_rv", 32'(s_rvalid), 32'd1);
      chk("s3_rdata", s_rdata, 32'h3C08_0001);
      next();
      data_ok = 0; rdata = 0;
      @(negedge clk);
      chk("s4_busy", 32'(s_busy), 32'd0);
      chk("s4_rv", 32'(s_rvalid), 32'd0);
      next();

      // Spurious data_ok, then held-data behaviour.
      do_rst();
      data_ok = 1; rdata = 32'h77;
      @(negedge clk);
      chk("sp_rv", 32'(m_rvalid), 32'd0);
      chk("sp_rdata", m_rdata, HOLD ? 32'h0 : 32'h77);
      next();
      data_ok = 0; core_req = 1; addr_ok = 1;
      @(negedge clk);
      chk("sp_busy_cnt0", 32'(m_busy), 32'd0);
      next();
      core_req = 0; addr_ok = 0;
      data_ok = 1; rdata = 32'h1234_5678;
      exp_q.push_back(32'h1234_5678);
      next();
      data_ok = 0;
      for (int k = 0; k < 5; k++) begin
         rdata = 32'hFFFF_0000 + 32'(k);
         @(negedge clk);
         chk($sformatf("hold%0d", k), m_rdata,
             HOLD ? 32'h1234_5678 : rdata);
         next();
      end
      core_req = 1; addr_ok = 1;
      next();
      core_req = 0; addr_ok = 0; flush = 1;
      next();
      flush = 0; data_ok = 1; rdata = 32'hDEAD;
      @(negedge clk);
      chk("drop_rv", 32'(m_rvalid), 32'd0);
      chk("drop_rdata", m_rdata,
          HOLD ? 32'h1234_5678 : 32'hDEAD);
      next();
      data_ok = 0; rdata = 0;
      @(negedge clk);
      chk("drop_busy", 32'(m_busy), 32'd0);
      chk("post_rdata", m_rdata,
          HOLD ? 32'h1234_5678 : 32'h0);
      next();

      chk("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
